// File: rtl/id_ex_operand_stage.sv
// Operand-fetch / ID-EX pipeline stage.
// Resolves rs/rt operands against the register bank read data plus three younger
// bypass points (EX, MEM, WB), detects load-use hazards (decode stall + bubble),
// extends the immediate and registers everything for EX behind a valid/ready
// handshake.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready           decode-side handshake (in_ready combinational)
//   in_rs/in_rt/in_rd           register addresses; in_uses_rs/rt operand-use flags
//   in_imm/in_imm_signed        raw immediate and its extension mode
//   in_ctrl                     opaque control word
//   rf_data_rs/rf_data_rt       bank read data
//   p1_*/p2_*/p3_*              EX/MEM/WB bypass sources (p1 also flags loads)
//   flush                       kill the stage contents
//   out_valid/out_ready         EX-side handshake
//   out_op_a/out_op_b/out_imm   resolved operands and extended immediate
//   out_rd/out_ctrl             destination and control word
//   load_use_stall              combinational load-use stall indication
//   stall_count                 saturating count of load-use stall cycles
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_uses_rs,
  input  logic              in_uses_rt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_imm_signed,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] rf_data_rs,
  input  logic [DATA_W-1:0] rf_data_rt,
  input  logic              p1_wen,
  input  logic [REG_AW-1:0] p1_rd,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p1_is_load,
  input  logic              p2_wen,
  input  logic [REG_AW-1:0] p2_rd,
  input  logic [DATA_W-1:0] p2_data,
  input  logic              p3_wen,
  input  logic [REG_AW-1:0] p3_rd,
  input  logic [DATA_W-1:0] p3_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              load_use_stall,
  output logic [15:0]       stall_count
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned EXT_W = DATA_W - IMM_W;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              adv;
  logic              p1_hit_rs, p1_hit_rt;
  logic [DATA_W-1:0] res_a, res_b, imm_ext;

  // Priority bypass for one operand; r0 and rd==0 sources never forward.
  // p3 is required because the bank writes on the same edge and its read is stale.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf
  );
    logic [DATA_W-1:0] r;
    if (addr == '0)                                      r = '0;
    else if (p1_wen && !p1_is_load && p1_rd == addr)     r = p1_data;
    else if (p2_wen && p2_rd == addr)                    r = p2_data;
    else if (p3_wen && p3_rd == addr)                    r = p3_data;
    else                                                 r = rf;
    return r;
  endfunction

  // Hazard detection and decode-side handshake.
  always_comb begin
    p1_hit_rs      = in_uses_rs && (p1_rd == in_rs);
    p1_hit_rt      = in_uses_rt && (p1_rd == in_rt);
    load_use_stall = in_valid && p1_wen && p1_is_load && (p1_rd != '0) &&
                     (p1_hit_rs || p1_hit_rt);
    adv            = !valid_q || out_ready;
    in_ready       = adv && !load_use_stall && !flush;
  end

  // Operand resolution and immediate extension.
  always_comb begin
    res_a   = resolve(in_rs, rf_data_rs);
    res_b   = resolve(in_rt, rf_data_rt);
    imm_ext = in_imm_signed ? {{EXT_W{in_imm[IMM_W-1]}}, in_imm} : DATA_W'(in_imm);
  end

  // Next-state: flush beats stall beats transfer; held while EX back-pressures.
  always_comb begin
    valid_d = valid_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = in_valid && !load_use_stall;
      if (in_valid && !load_use_stall) begin
        op_a_d = res_a;
        op_b_d = res_b;
        imm_d  = imm_ext;
        rd_d   = in_rd;
        ctrl_d = in_ctrl;
      end
    end
    if (load_use_stall && !flush && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_op_a    = op_a_q;
  assign out_op_b    = op_b_q;
  assign out_imm     = imm_q;
  assign out_rd      = rd_q;
  assign out_ctrl    = ctrl_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_uses_rs, in_uses_rt;
  logic [15:0] in_imm;
  logic        in_imm_signed;
  logic [11:0] in_ctrl;
  logic [31:0] rf_data_rs, rf_data_rt;
  logic        p1_wen, p1_is_load;
  logic [4:0]  p1_rd;
  logic [31:0] p1_data;
  logic        p2_wen;
  logic [4:0]  p2_rd;
  logic [31:0] p2_data;
  logic        p3_wen;
  logic [4:0]  p3_rd;
  logic [31:0] p3_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b, out_imm;
  logic [4:0]  out_rd;
  logic [11:0] out_ctrl;
  logic        load_use_stall;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic [11:0] m_ctrl;
  logic [15:0] m_cnt;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_imm(in_imm), .in_imm_signed(in_imm_signed), .in_ctrl(in_ctrl),
    .rf_data_rs(rf_data_rs), .rf_data_rt(rf_data_rt),
    .p1_wen(p1_wen), .p1_rd(p1_rd), .p1_data(p1_data), .p1_is_load(p1_is_load),
    .p2_wen(p2_wen), .p2_rd(p2_rd), .p2_data(p2_data),
    .p3_wen(p3_wen), .p3_rd(p3_rd), .p3_data(p3_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value the instruction should see for register a: the youngest writer in flight
  // wins (a load in EX cannot forward yet), else the bank; r0 is hardwired zero.
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    logic        w [3];
    logic [4:0]  r [3];
    logic [31:0] d [3];
    w = '{p1_wen && !p1_is_load, p2_wen, p3_wen};
    r = '{p1_rd, p2_rd, p3_rd};
    d = '{p1_data, p2_data, p3_data};
    if (a == 5'd0) return 32'd0;
    for (int k = 0; k < 3; k++)
      if (w[k] && r[k] == a) return d[k];
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_imm = '0; m_rd = '0; m_ctrl = '0; m_cnt = '0;
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_uses_rs = 0; in_uses_rt = 0;
    in_imm = 0; in_imm_signed = 0; in_ctrl = 0; rf_data_rs = 0; rf_data_rt = 0;
    p1_wen = 0; p1_rd = 0; p1_data = 0; p1_is_load = 0;
    p2_wen = 0; p2_rd = 0; p2_data = 0;
    p3_wen = 0; p3_rd = 0; p3_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({ctx, ".stall_count"}, 32'(stall_count), 32'(m_cnt));
    if (m_valid) begin
      chk({ctx, ".op_a"}, out_op_a, m_a);
      chk({ctx, ".op_b"}, out_op_b, m_b);
      chk({ctx, ".imm"}, out_imm, m_imm);
      chk({ctx, ".rd"}, 32'(out_rd), 32'(m_rd));
      chk({ctx, ".ctrl"}, 32'(out_ctrl), 32'(m_ctrl));
    end
  endtask

  // One clock: inputs already driven; check combinational outputs, advance model
  // and DUT across the edge, then check registered outputs.
  task automatic cycle(input string ctx);
    logic reads_load, hold, take;
    #1;
    reads_load = in_valid && p1_wen && p1_is_load && p1_rd != 5'd0 &&
                 ((in_uses_rs && in_rs == p1_rd) || (in_uses_rt && in_rt == p1_rd));
    hold = m_valid && !out_ready;
    take = in_valid && !reads_load && !hold && !flush;
    chk({ctx, ".stall"}, 32'(load_use_stall), 32'(reads_load));
    chk({ctx, ".in_ready"}, 32'(in_ready), 32'(!reads_load && !hold && !flush));
    if (flush) m_valid = 1'b0;
    else if (!hold) m_valid = take;
    if (take) begin
      m_a    = ref_operand(in_rs, rf_data_rs);
      m_b    = ref_operand(in_rt, rf_data_rt);
      m_imm  = in_imm_signed ? 32'($signed(in_imm)) : {16'd0, in_imm};
      m_rd   = in_rd;
      m_ctrl = in_ctrl;
    end
    if (reads_load && !flush && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #12;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.stall_count", 32'(stall_count), 32'd0);
    chk("reset.op_a", out_op_a, 32'd0);
    rst = 1'b0;

    // No hazards, signed immediate
    in_valid = 1; in_rs = 3; in_rt = 4; in_rd = 9; in_uses_rs = 1; in_uses_rt = 1;
    rf_data_rs = 32'h11; rf_data_rt = 32'h22; in_imm = 16'h8000; in_imm_signed = 1;
    in_ctrl = 12'hA5C;
    cycle("nohaz");
    chk("nohaz.op_a_const", out_op_a, 32'h11);
    chk("nohaz.imm_const", out_imm, 32'hFFFF8000);

    // Zero register never forwards
    in_rs = 0; p1_wen = 1; p1_rd = 0; p1_data = 32'hDEAD; rf_data_rs = 32'h5;
    in_imm_signed = 0;
    cycle("zero");
    chk("zero.op_a_const", out_op_a, 32'd0);
    chk("zero.imm_const", out_imm, 32'h00008000);

    // Priority p1 > p2 > p3
    in_rs = 7; p1_wen = 1; p1_rd = 7; p1_data = 32'hA;
    p2_wen = 1; p2_rd = 7; p2_data = 32'hB; p3_wen = 1; p3_rd = 7; p3_data = 32'hC;
    cycle("prio1");
    chk("prio1.const", out_op_a, 32'hA);
    p1_wen = 0;
    cycle("prio2");
    chk("prio2.const", out_op_a, 32'hB);
    p2_wen = 0;
    cycle("prio3");
    chk("prio3.const", out_op_a, 32'hC);

    // Load-use: one bubble, then p2 supplies the loaded value
    idle();
    in_valid = 1; in_rs = 5; in_rt = 6; in_uses_rs = 1; in_uses_rt = 1; in_rd = 2;
    p1_wen = 1; p1_rd = 5; p1_is_load = 1; p1_data = 32'h99;
    cycle("lu.stall");
    chk("lu.count_const", 32'(stall_count), 32'd1);
    p1_wen = 0; p1_is_load = 0; p2_wen = 1; p2_rd = 5; p2_data = 32'h77;
    cycle("lu.fwd");
    chk("lu.fwd_const", out_op_a, 32'h77);
    // Unused operand does not stall
    in_uses_rs = 0; p1_wen = 1; p1_rd = 5; p1_is_load = 1; p2_wen = 0;
    cycle("lu.unused");

    // Backpressure with toggling bypass inputs
    idle();
    in_valid = 1; in_rs = 1; in_rt = 2; in_uses_rs = 1; in_uses_rt = 1;
    rf_data_rs = 32'h1234; rf_data_rt = 32'h5678; in_rd = 3; in_ctrl = 12'h111;
    cycle("bp.xfer");
    out_ready = 0; in_rd = 4; in_ctrl = 12'h222;
    for (int i = 0; i < 3; i++) begin
      p1_wen = 1; p1_rd = 1; p1_data = $urandom;
      p2_wen = 1; p2_rd = 2; p2_data = $urandom;
      cycle("bp.hold");
      chk("bp.hold_const", out_op_a, 32'h1234);
    end
    out_ready = 1;
    cycle("bp.release");
    chk("bp.release_rd", 32'(out_rd), 32'd4);

    // Flush coincident with load-use stall
    idle();
    in_valid = 1; in_rs = 5; in_uses_rs = 1;
    p1_wen = 1; p1_rd = 5; p1_is_load = 1; flush = 1;
    cycle("flush");
    chk("flush.count_const", 32'(stall_count), 32'd1);

    // Reset mid-valid
    idle();
    in_valid = 1; in_rs = 8; in_rt = 9; rf_data_rs = 32'hCAFE; rf_data_rt = 32'hBEEF;
    in_imm = 16'h7FFF; in_imm_signed = 1; in_rd = 10; in_ctrl = 12'hFFF; out_ready = 0;
    cycle("pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.op_a", out_op_a, 32'd0);
    chk("rst.op_b", out_op_b, 32'd0);
    chk("rst.imm", out_imm, 32'd0);
    chk("rst.rd", 32'(out_rd), 32'd0);
    chk("rst.ctrl", 32'(out_ctrl), 32'd0);
    chk("rst.stall_count", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 400; i++) begin
      in_valid      = ($urandom_range(0, 9) < 8);
      in_rs         = 5'($urandom_range(0, 7));
      in_rt         = 5'($urandom_range(0, 7));
      in_rd         = 5'($urandom);
      in_uses_rs    = 1'($urandom);
      in_uses_rt    = 1'($urandom);
      in_imm        = 16'($urandom);
      in_imm_signed = 1'($urandom);
      in_ctrl       = 12'($urandom);
      rf_data_rs    = $urandom;
      rf_data_rt    = $urandom;
      p1_wen        = 1'($urandom);
      p1_rd         = 5'($urandom_range(0, 7));
      p1_data       = $urandom;
      p1_is_load    = ($urandom_range(0, 3) == 0);
      p2_wen        = 1'($urandom);
      p2_rd         = 5'($urandom_range(0, 7));
      p2_data       = $urandom;
      p3_wen        = 1'($urandom);
      p3_rd         = 5'($urandom_range(0, 7));
      p3_data       = $urandom;
      flush         = ($urandom_range(0, 15) == 0);
      out_ready     = ($urandom_range(0, 9) < 7);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
